luhn_checker: RTL and testbench

Downstream consumer of the PS/2 key converter. Captures one-hot digits into a shift register of decimal digits on each "shift" request. On a "check" request it runs a sequential Luhn (mod-10) checksum over the stored digits, one digit per clock, and reports pass/fail. It sits between the keyboard front end and the display/result logic of the card-number validator.

---
 rtl/luhn_pkg.sv | 17 +
 rtl/onehot10_to_bcd.sv | 17 +
 rtl/luhn_checker.sv | 123 ++++++++++++
 tb/tb_luhn_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/luhn_pkg.sv
// Shared definitions for the card-number Luhn checker: FSM encoding,
// default capacity and the active-low request polarity of the converter.
package luhn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } luhn_state_t;

    localparam int DEFAULT_MAX_DIGITS = 16;

    // Requests from the PS/2 converter are asserted low
    localparam logic SHIFT_ON     = 1'b0;
    localparam logic CHCK_LUHN_ON = 1'b0;

endpackage

// File: rtl/onehot10_to_bcd.sv
// Converts a one-hot decimal key code to BCD; ok is high only for
// exactly one set bit, so idle and chorded keys are rejected.
module onehot10_to_bcd (
    input  logic [9:0] number,
    output logic [3:0] bcd,
    output logic       ok
);

    always_comb begin
        bcd = 4'd0;
        ok  = ($countones(number) == 1);
        for (int k = 0; k < 10; k++) begin
            if (number[k]) bcd = 4'(k);
        end
    end

endmodule

// File: rtl/luhn_checker.sv
// Collects keyed digits into a BCD shift register and runs a Luhn (mod-10)
// checksum over them one digit per clock on request.
module luhn_checker
    import luhn_pkg::*;
#(
    parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS,
    parameter int CW         = 5
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [9:0]              number,
    input  logic                    shift,
    input  logic                    check_luhn,
    output logic [4*MAX_DIGITS-1:0] digits,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [3:0]              checksum
);

    luhn_state_t state, state_next;

    logic          shift_q, check_q;
    logic [CW-1:0] idx;
    logic [3:0]    acc, acc_next;
    logic [3:0]    bcd, d_sel, v;
    logic [4:0]    dbl, sum5;
    logic          bcd_ok;
    logic          shift_edge, check_edge;
    logic          commit_ok, check_go, last_step;

    onehot10_to_bcd u_decode (
        .number (number),
        .bcd    (bcd),
        .ok     (bcd_ok)
    );

    assign full = (count == CW'(MAX_DIGITS));
    assign busy = (state == RUN);

    // Request decode and the single Luhn step for the digit at idx
    always_comb begin
        shift_edge = shift_q && (shift == SHIFT_ON);
        check_edge = check_q && (check_luhn == CHCK_LUHN_ON);
        commit_ok  = shift_edge && (state != RUN) && bcd_ok && (count < CW'(MAX_DIGITS));
        check_go   = check_edge && (state != RUN) && !commit_ok;
        last_step  = (state == RUN) && (idx == count - CW'(1));

        d_sel = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (idx == CW'(i)) d_sel = digits[4*i +: 4];
        end

        dbl = {d_sel, 1'b0};
        if (idx[0]) v = (dbl > 5'd9) ? 4'(dbl - 5'd9) : dbl[3:0];
        else        v = d_sel;

        sum5     = {1'b0, acc} + {1'b0, v};
        acc_next = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (commit_ok)     state_next = IDLE;
                else if (check_go) state_next = (count == '0) ? DONE : RUN;
            end
            RUN:     if (last_step) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shift_q  <= 1'b1;
            check_q  <= 1'b1;
            digits   <= '0;
            count    <= '0;
            idx      <= '0;
            acc      <= 4'd0;
            done     <= 1'b0;
            valid    <= 1'b0;
            checksum <= 4'd0;
        end else begin
            shift_q <= shift;
            check_q <= check_luhn;
            if (commit_ok) begin
                digits   <= {digits[4*MAX_DIGITS-5:0], bcd};
                count    <= count + CW'(1);
                done     <= 1'b0;
                valid    <= 1'b0;
                checksum <= 4'd0;
            end else if (check_go) begin
                if (count == '0) begin
                    done     <= 1'b1;
                    valid    <= 1'b0;
                    checksum <= 4'd0;
                end else begin
                    idx  <= '0;
                    acc  <= 4'd0;
                    done <= 1'b0;
                end
            end else if (state == RUN) begin
                acc <= acc_next;
                idx <= idx + CW'(1);
                if (last_step) begin
                    done     <= 1'b1;
                    checksum <= acc_next;
                    valid    <= (acc_next == 4'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_luhn_checker.sv
// Directed and randomized checks of luhn_checker against a queue-based
// Luhn model (most recent digit at the front of the queue).
module tb_luhn_checker;

    localparam int MAXD = 16;
    localparam int CWD  = 5;

    logic              CLOCK_50 = 1'b0;
    logic              resetn;
    logic [9:0]        number;
    logic              shift;
    logic              check_luhn;
    logic [4*MAXD-1:0] digits;
    logic [CWD-1:0]    count;
    logic              full, busy, done, valid;
    logic [3:0]        checksum;

    int total  = 0;
    int passed = 0;
    int model_q[$];

    luhn_checker #(.MAX_DIGITS(MAXD), .CW(CWD)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .number     (number),
        .shift      (shift),
        .check_luhn (check_luhn),
        .digits     (digits),
        .count      (count),
        .full       (full),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .checksum   (checksum)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [63:0] modelDigits();
        logic [63:0] r = '0;
        foreach (model_q[i]) r[4*i +: 4] = 4'(model_q[i]);
        return r;
    endfunction

    function automatic int modelSum();
        int s = 0;
        foreach (model_q[i]) begin
            int v = (i % 2 == 1) ? model_q[i] * 2 : model_q[i];
            if (v > 9) v -= 9;
            s += v;
        end
        return s % 10;
    endfunction

    task automatic doReset();
        resetn = 1'b0; shift = 1'b1; check_luhn = 1'b1; number = '0;
        tick();
        resetn = 1'b1;
        model_q.delete();
        tick();
    endtask

    // One shift pulse; the model accepts only exactly-one-hot codes below capacity
    task automatic applyStimulus(input logic [9:0] num);
        number = num;
        shift  = 1'b0;
        tick();
        shift  = 1'b1;
        if ($countones(num) == 1 && model_q.size() < MAXD) begin
            for (int k = 0; k < 10; k++) if (num[k]) model_q.push_front(k);
        end
        tick();
    endtask

    task automatic runCheck(input string tag);
        int cycles = 0;
        int n = model_q.size();
        check_luhn = 1'b0;
        tick();
        check_luhn = 1'b1;
        checkOutput({tag, "_busyE"}, 64'(busy), 64'(n > 0));
        while (!done && cycles < 64) begin
            tick();
            cycles++;
        end
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(n));
        checkOutput({tag, "_busyend"}, 64'(busy), 64'd0);
        checkOutput({tag, "_valid"}, 64'(valid), 64'(n > 0 && modelSum() == 0));
        checkOutput({tag, "_checksum"}, 64'(checksum), 64'(n > 0 ? modelSum() : 0));
    endtask

    initial begin
        int seq1[11] = '{7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 3};
        int cyc;

        resetn = 1'b0; shift = 1'b1; check_luhn = 1'b1; number = '0;
        #3;
        checkOutput("rst_digits", digits, 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_flags", {60'd0, full, busy, done, valid}, 64'd0);
        checkOutput("rst_checksum", 64'(checksum), 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("[TB] valid card sequence");
        foreach (seq1[i]) begin
            applyStimulus(10'(1) << seq1[i]);
            checkOutput("seq1_digit0", 64'(digits[3:0]), 64'(seq1[i]));
        end
        checkOutput("seq1_count", 64'(count), 64'd11);
        runCheck("seq1");
        checkOutput("seq1_valid_abs", 64'(valid), 64'd1);
        checkOutput("seq1_sum_abs", 64'(checksum), 64'd0);

        $display("[TB] invalid card sequence");
        doReset();
        seq1[10] = 4;
        foreach (seq1[i]) applyStimulus(10'(1) << seq1[i]);
        runCheck("seq2");
        checkOutput("seq2_sum_abs", 64'(checksum), 64'd1);

        $display("[TB] held shift");
        doReset();
        number = 10'b0000100000;
        shift  = 1'b0;
        repeat (100) tick();
        shift  = 1'b1;
        tick();
        checkOutput("hold_count", 64'(count), 64'd1);
        checkOutput("hold_digit", 64'(digits[3:0]), 64'd5);

        $display("[TB] overflow");
        doReset();
        repeat (17) applyStimulus(10'b0000000010);
        checkOutput("ovf_count", 64'(count), 64'd16);
        checkOutput("ovf_full", 64'(full), 64'd1);
        checkOutput("ovf_digits", digits, modelDigits());

        $display("[TB] empty check");
        doReset();
        runCheck("empty");
        checkOutput("empty_done", 64'(done), 64'd1);
        applyStimulus(10'b0000000000);
        applyStimulus(10'b0000000011);
        checkOutput("empty_count", 64'(count), 64'd0);
        checkOutput("empty_done_hold", 64'(done), 64'd1);

        $display("[TB] requests during run");
        doReset();
        seq1[10] = 3;
        foreach (seq1[i]) applyStimulus(10'(1) << seq1[i]);
        check_luhn = 1'b0;
        tick();
        check_luhn = 1'b1;
        cyc = 0;
        while (!done && cyc < 64) begin
            if (cyc == 2) begin
                number = 10'b0000000100; shift = 1'b0; check_luhn = 1'b0;
            end else begin
                shift = 1'b1; check_luhn = 1'b1;
            end
            tick();
            cyc++;
        end
        shift = 1'b1; check_luhn = 1'b1;
        checkOutput("inj_latency", 64'(cyc), 64'd11);
        checkOutput("inj_count", 64'(count), 64'd11);
        checkOutput("inj_digits", digits, modelDigits());
        checkOutput("inj_result", {valid, checksum}, {1'b1, 4'd0});

        $display("[TB] reset during run");
        check_luhn = 1'b0;
        tick();
        check_luhn = 1'b1;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        checkOutput("abort_flags", {60'd0, full, busy, done, valid}, 64'd0);
        checkOutput("abort_state", {digits[59:0], checksum}, 64'd0);
        checkOutput("abort_count", 64'(count), 64'd0);
        tick();
        resetn = 1'b1;
        model_q.delete();
        tick();

        $display("[TB] random cards");
        for (int r = 0; r < 12; r++) begin
            int len = $urandom_range(1, MAXD + 2);
            doReset();
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 5) == 0) applyStimulus(10'($urandom_range(0, 1023)));
                else applyStimulus(10'(1) << $urandom_range(0, 9));
            end
            checkOutput("rnd_count", 64'(count), 64'(model_q.size()));
            checkOutput("rnd_digits", digits, modelDigits());
            runCheck("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
